// File: rtl/axi4s2data.sv
// axi4s2data: AXI4-Stream slave for fixed-length packets.
// Accepted beats are buffered in a small FIFO and presented on a valid/ready
// port with sop/eop markers. Each packet's tlast is checked against the
// expected length. Framing errors pulse for one cycle and never drop data.
module axi4s2data #(
  parameter int DATA_WIDTH  = 64,
  parameter int PACKET_BYTE = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  input  logic                  tlast,
  output logic                  tready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_early,
  output logic                  err_missing,
  output logic [31:0]           pkt_count
);

  localparam int BEATS = PACKET_BYTE / (DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(BEATS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // FIFO entry layout: {data, sop, eop}
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic             tready_q, tready_d;
  logic             err_early_q, err_early_d;
  logic             err_missing_q, err_missing_d;
  logic [31:0]      pkt_count_q, pkt_count_d;

  logic             push;
  logic             pop;
  logic             last_beat;
  logic [ENT_W-1:0] head;

  // Handshakes, framing check and FIFO bookkeeping.
  always_comb begin
    push          = tvalid & tready_q;
    pop           = (count_q != '0) & out_ready;
    last_beat     = (beat_idx_q == LAST_IDX);

    beat_idx_d    = beat_idx_q;
    err_early_d   = 1'b0;
    err_missing_d = 1'b0;
    pkt_count_d   = pkt_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      // Any tlast or the final beat position ends the packet, so a framing
      // error resynchronises on the very next beat.
      if (tlast || last_beat) begin
        beat_idx_d = '0;
      end else begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end
      if (tlast && !last_beat) begin
        err_early_d = 1'b1;
      end
      if (!tlast && last_beat) begin
        err_missing_d = 1'b1;
      end
      if (tlast && last_beat) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Looking at the post-update occupancy keeps a push off a full FIFO.
    tready_d = (count_d < FULL_CNT);
  end

  // Control state registers; reset discards any partial packet silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      beat_idx_q    <= '0;
      tready_q      <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      pkt_count_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_idx_q    <= beat_idx_d;
      tready_q      <= tready_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  // FIFO storage write; contents need no reset because the count gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tdata, (beat_idx_q == '0), tlast};
    end
  end

  // Head entry, forced to zero while empty so stale storage never shows.
  always_comb begin
    head = '0;
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_data    = head[ENT_W-1:2];
  assign out_sop     = head[1];
  assign out_eop     = head[0];
  assign out_valid   = (count_q != '0);
  assign tready      = tready_q;
  assign err_early   = err_early_q;
  assign err_missing = err_missing_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axi4s2data.sv
// Directed bench for axi4s2data at default parameters (BEATS=8, FIFO_DEPTH=4).
// Every pop is compared against a queue of beats the bench itself expects.
module tb_axi4s2data;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_early;
  logic        err_missing;
  logic [31:0] pkt_count;

  int n_cmp = 0;
  int n_bad = 0;
  int early_cnt = 0;
  int missing_cnt = 0;
  int last_wait = 0;
  int stalls = 0;
  int acc = 0;
  logic [65:0] exp_q[$];

  axi4s2data dut (
    .clk(clk), .rst_n(rst_n), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
    .tready(tready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready), .err_early(err_early),
    .err_missing(err_missing), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: verify a pop due at the coming edge, then step past the edge.
  task automatic tick();
    logic [65:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pop_beat", {out_data, out_sop, out_eop}, e);
      end
    end
    @(posedge clk);
    #1;
    early_cnt   += int'(err_early);
    missing_cnt += int'(err_missing);
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [63:0] d, input logic last, input logic exp_sop);
    int w;
    w = 0;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    while (!tready && w < 50) begin
      tick();
      w++;
    end
    last_wait = w;
    if (!tready) begin
      check("tready_timeout", 0, 1);
    end else begin
      exp_q.push_back({d, exp_sop, last});
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    // Reset with tvalid high: nothing may be accepted.
    tvalid = 1'b1;
    tdata  = 64'hDEAD_BEEF;
    repeat (5) tick();
    check("rst_tready", tready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", {out_data, out_sop, out_eop}, 0);
    check("rst_err", {err_early, err_missing}, 0);
    check("rst_pkt_count", pkt_count, 0);
    tvalid = 1'b0;
    rst_n  = 1'b1;
    tick();
    check("tready_rise", tready, 1);
    check("no_push_in_reset", out_valid, 0);

    // Loopback-style stream of 100 counting beats, out_ready held high.
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      send(64'(k), (k % 8) == 7, (k % 8) == 0);
      if (last_wait != 0) stalls++;
    end
    repeat (3) tick();
    check("loop_pkt_count", pkt_count, 12);
    check("loop_stalls", stalls, 0);
    check("loop_errors", {early_cnt[15:0], missing_cnt[15:0]}, 0);
    check("loop_drained", exp_q.size(), 0);
    for (int k = 100; k < 104; k++) send(64'(k), k == 103, 1'b0);
    tick();
    check("loop_pkt13", pkt_count, 13);

    // Backpressure: out_ready low, continuous offer.
    out_ready = 1'b0;
    acc = 0;
    tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tdata = 64'(200 + acc);
      if (tready) begin
        exp_q.push_back({tdata, acc == 0, 1'b0});
        acc++;
      end
      tick();
    end
    tvalid = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_tready_low", tready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_tready_back", tready, 1);
    repeat (4) tick();
    check("bp_drained", exp_q.size(), 0);
    for (int k = 204; k < 208; k++) send(64'(k), k == 207, 1'b0);
    check("bp_pkt14", pkt_count, 14);

    // Early tlast on beat 3.
    for (int k = 0; k < 4; k++) send(64'(300 + k), k == 3, k == 0);
    check("early_pulse", err_early, 1);
    check("early_pkt_same", pkt_count, 14);
    tick();
    check("early_one_cycle", err_early, 0);
    for (int k = 0; k < 8; k++) send(64'(310 + k), k == 7, k == 0);
    check("early_then_good", pkt_count, 15);
    check("early_count", early_cnt, 1);

    // Missing tlast: 8 beats with no tlast.
    for (int k = 0; k < 8; k++) send(64'(400 + k), 1'b0, k == 0);
    check("missing_pulse", err_missing, 1);
    check("missing_pkt_same", pkt_count, 15);
    tick();
    check("missing_one_cycle", err_missing, 0);
    for (int k = 0; k < 8; k++) send(64'(410 + k), k == 7, k == 0);
    check("missing_then_good", pkt_count, 16);
    check("missing_count", missing_cnt, 1);
    repeat (3) tick();

    // Reset in the middle of a packet.
    for (int k = 0; k < 5; k++) send(64'(500 + k), 1'b0, k == 0);
    out_ready = 1'b0;
    send(64'(505), 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    check("midrst_empty", out_valid, 0);
    check("midrst_pkt_count", pkt_count, 0);
    rst_n = 1'b1;
    tick();
    early_cnt = 0;
    missing_cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(64'(600 + k), k == 7, k == 0);
    repeat (3) tick();
    check("fresh_pkt_count", pkt_count, 1);
    check("fresh_no_errors", {early_cnt[15:0], missing_cnt[15:0]}, 0);
    check("fresh_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4s2data.md
# axi4s2data

Receive-side counterpart of `data2axi4s`. The block is an AXI4-Stream slave that accepts fixed-length packets of `PACKET_BYTE` bytes and checks their framing against `tlast`. Accepted beats are buffered in a small FIFO and presented on a valid/ready data port with start/end-of-packet markers. It sits at the consumer end of a `data2axi4s` link and provides loopback checking of the transmitter.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: width of `tdata` and `out_data` in bits; must be a multiple of 8.
- `PACKET_BYTE`, default 64: packet length in bytes; must be a multiple of `DATA_WIDTH/8`. `BEATS = PACKET_BYTE/(DATA_WIDTH/8)` (8 at defaults). `BEATS` must be ≥ 2.
- `FIFO_DEPTH`, default 4: buffer entries; must be a power of 2 and ≥ 2.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `tdata` in `DATA_WIDTH`: stream data.
- `tvalid` in 1: stream valid.
- `tlast` in 1: stream end of packet.
- `tready` out 1: stream ready; registered.
- `out_data` out `DATA_WIDTH`: FIFO head data.
- `out_sop` out 1: head beat is beat 0 of a packet.
- `out_eop` out 1: head beat carried `tlast`.
- `out_valid` out 1: FIFO is not empty.
- `out_ready` in 1: downstream pops the head when it is high together with `out_valid`.
- `err_early` out 1: one-cycle pulse; `tlast` arrived before beat `BEATS-1`.
- `err_missing` out 1: one-cycle pulse; beat `BEATS-1` arrived without `tlast`.
- `pkt_count` out 32: number of correctly framed packets received; wraps at 2^32.

## Operation
- A beat is accepted when `tvalid & tready` is high at a rising edge.
- On accept, push `{tdata, sop = (beat_idx==0), eop = tlast}` into the FIFO.
- `beat_idx` is a `$clog2(BEATS)`-bit counter, 0..`BEATS-1`.
  - Increments on each accepted beat.
  - Returns to 0 after any beat with `tlast`, and after beat `BEATS-1` whether or not `tlast` was present. This keeps framing resynchronised.
- Framing check on each accepted beat:
  - `tlast` with `beat_idx` < `BEATS-1`: pulse `err_early`; the counter restarts at 0.
  - `tlast` with `beat_idx == BEATS-1`: correct packet; `pkt_count` += 1.
  - No `tlast` with `beat_idx == BEATS-1`: pulse `err_missing`; the counter restarts at 0. The next beat is treated as sop.
- Errors never drop data. All beats are forwarded.
- FIFO behaviour:
  - `out_valid = (count != 0)`.
  - `out_data`, `out_sop` and `out_eop` come from the head entry.
  - A pop occurs on `out_valid & out_ready`.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits, wrap modulo `FIFO_DEPTH`, and `count` is 0..`FIFO_DEPTH`.
  - A simultaneous push and pop leaves `count` unchanged.
- `tready` register: next value is `(count_next < FIFO_DEPTH)`, where `count_next` includes this cycle's push and pop. No push can occur while the FIFO is full, so overflow is impossible. A pop on a full FIFO raises `tready` in the following cycle.
- Popping an empty FIFO is impossible, because a pop is gated by `out_valid`.

## Timing
- Reset (`rst_n` low at an edge) clears:
  - `tready`=0, `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0
  - `err_early`=0, `err_missing`=0, `pkt_count`=0
  - `beat_idx`=0, both pointers 0, `count`=0
- `tready` rises at the first edge with `rst_n` high.
- Reset in the middle of a packet discards the FIFO contents and the partial packet with no error pulse. The next accepted beat is beat 0.
- Latency: a beat accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N, provided the FIFO was empty.
- `err_*` pulse and `pkt_count` update: registered, visible after the accepting edge N for exactly one cycle (for the errors).
- With `out_ready` held at 1, sustained throughput is 1 beat per cycle and `tready` stays at 1.
- With `out_ready`=0, the FIFO accepts `FIFO_DEPTH` beats. `tready` falls after the edge of the `FIFO_DEPTH`-th accept.

## Test plan
- Reset behaviour: hold `rst_n`=0 for 5 cycles with `tvalid`=1 → `tready`=0, all outputs 0, no push.
- Loopback with `data2axi4s`: connect `data2axi4s` (`PACKET_BYTE`=64) as the source and hold `out_ready`=1. Drive a counting input `in_data` that starts at 0 and is captured per beat.
  - Required: `out_data` follows that sequence with no gaps or duplicates.
  - `out_sop` is high on beats 0, 8, 16, …
  - `out_eop` is high on beats 7, 15, …
  - After 100 beats, `pkt_count`=12 and no error pulses.
- Backpressure: hold `out_ready`=0 and stream continuously → exactly 4 beats are accepted and `tready`=0. Then set `out_ready`=1 → the 4 beats drain in order and `tready` returns to 1 one cycle after the first pop.
- Early `tlast` (`BEATS`=8): assert `tlast` on beat 3 → `err_early` is 1 for one cycle, `pkt_count` is unchanged, and the next beat has `out_sop`=1. A following correct 8-beat packet gives `pkt_count`+1.
- Missing `tlast`: send 8 beats with `tlast`=0 → `err_missing` pulses after beat 7 and beat 8 has `out_sop`=1.
- Reset during a packet: assert reset after beat 5 → the FIFO is empty after reset. A fresh packet then gives a clean count of 1 with no errors.
